// File: rtl/sdft_bin_reader.sv
// Frame reader for the sdft bin RAM: walks every bin after a rising edge of sdft_ready
// and streams an alpha-max-beta-min magnitude per bin over a valid/accept handshake.
//
// state | meaning
// IDLE  | waiting for a rising edge of sdft_ready
// READ  | bin_addr presented to the bin RAM, waiting one cycle of read latency
// CAPT  | RAM data valid; absolute values of real/imag registered
// CALC  | magnitude, bin index and last flag registered; mag_valid raised
// HOLD  | outputs frozen until the sink accepts
module sdft_bin_reader #(
  parameter  int data_width = 8,
  parameter  int freq_bins  = 16,
  localparam int BW         = 2 * data_width + 1,
  localparam int AW         = $clog2(freq_bins)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sdft_ready,
  output logic [AW-1:0]        bin_addr,
  input  logic signed [BW-1:0] bin_real,
  input  logic signed [BW-1:0] bin_imag,
  output logic [BW-1:0]        mag,
  output logic [AW-1:0]        mag_bin,
  output logic                 mag_valid,
  output logic                 mag_last,
  input  logic                 mag_accept,
  output logic                 busy,
  output logic                 frame_drop
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    CALC = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_ready_q;
  logic [AW-1:0]   r_bin_addr;
  logic [BW-1:0]   r_ar;
  logic [BW-1:0]   r_ai;
  logic [BW-1:0]   r_mag;
  logic [AW-1:0]   r_mag_bin;
  logic            r_mag_valid;
  logic            r_mag_last;
  logic            r_frame_drop;

  logic            w_start;
  logic            w_abort;
  logic            w_xfer;
  logic [BW-1:0]   w_abs_re;
  logic [BW-1:0]   w_abs_im;
  logic [BW-1:0]   w_mx;
  logic [BW-1:0]   w_mn;
  logic [BW+1:0]   w_mn3;
  logic [BW-1:0]   w_mag;

  assign w_start = (r_state == IDLE) && sdft_ready && !r_ready_q;
  assign w_abort = (r_state != IDLE) && !sdft_ready;
  assign w_xfer  = (r_state == HOLD) && r_mag_valid && mag_accept;

  // Negating the most negative value wraps to 2^(BW-1), which is exact as unsigned.
  assign w_abs_re = bin_real[BW-1] ? $unsigned(-bin_real) : $unsigned(bin_real);
  assign w_abs_im = bin_imag[BW-1] ? $unsigned(-bin_imag) : $unsigned(bin_imag);

  assign w_mx  = (r_ar >= r_ai) ? r_ar : r_ai;
  assign w_mn  = (r_ar >= r_ai) ? r_ai : r_ar;
  assign w_mn3 = {2'b00, w_mn} + {1'b0, w_mn, 1'b0};
  // mx + 3/8*mn never exceeds 1.375 * 2^(BW-1), so the BW-bit sum cannot wrap.
  assign w_mag = w_mx + BW'(w_mn3 >> 3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_start) w_state_nxt = READ;
      READ: w_state_nxt = CAPT;
      CAPT: w_state_nxt = CALC;
      CALC: w_state_nxt = HOLD;
      HOLD: if (w_xfer) w_state_nxt = r_mag_last ? IDLE : READ;
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready_q    <= 1'b1;
      r_bin_addr   <= '0;
      r_ar         <= '0;
      r_ai         <= '0;
      r_mag        <= '0;
      r_mag_bin    <= '0;
      r_mag_valid  <= 1'b0;
      r_mag_last   <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_ready_q    <= sdft_ready;
      r_frame_drop <= w_abort;
      if (w_abort) begin
        r_bin_addr  <= '0;
        r_mag_valid <= 1'b0;
        r_mag_last  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (w_start) r_bin_addr <= '0;
          CAPT: begin
            r_ar <= w_abs_re;
            r_ai <= w_abs_im;
          end
          CALC: begin
            r_mag       <= w_mag;
            r_mag_bin   <= r_bin_addr;
            r_mag_last  <= (r_bin_addr == AW'(freq_bins - 1));
            r_mag_valid <= 1'b1;
          end
          HOLD: begin
            if (w_xfer) begin
              r_mag_valid <= 1'b0;
              r_bin_addr  <= r_mag_last ? '0 : r_bin_addr + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bin_addr   = r_bin_addr;
  assign mag        = r_mag;
  assign mag_bin    = r_mag_bin;
  assign mag_valid  = r_mag_valid;
  assign mag_last   = r_mag_last;
  assign busy       = (r_state != IDLE);
  assign frame_drop = r_frame_drop;

endmodule
